// File: rtl/seq_divider_16.sv
// seq_divider_16: unsigned restoring divider, one quotient bit per cycle, MSB first.
// Valid/ready handshake on both sides; a zero divisor short-circuits straight to DONE.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, qw_q, qw_d, quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH:0] pr_q, pr_d, pr_sh, trial;
    logic dbz_q, dbz_d, accept, last, ge;

    assign accept = in_valid & in_ready;
    assign last   = cnt_q == 5'(WIDTH - 1);
    // dvd_q shifts left each iteration, so its MSB is always the next dividend bit
    assign pr_sh  = (pr_q << 1) | (WIDTH+1)'(dvd_q[WIDTH-1]);
    assign trial  = pr_sh - {1'b0, dvs_q};
    assign ge     = ~trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (divisor == '0) ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end

    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        pr_d  = pr_q;
        qw_d  = qw_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        if (accept) begin
            dvd_d = dividend;
            dvs_d = divisor;
            pr_d  = '0;
            cnt_d = '0;
            qw_d  = '0;
            if (divisor == '0) begin
                quo_d = '1;
                rem_d = dividend;
                dbz_d = 1'b1;
            end
        end else if (state_q == CALC) begin
            pr_d  = ge ? trial : pr_sh;
            qw_d  = {qw_q[WIDTH-2:0], ge};
            dvd_d = dvd_q << 1;
            cnt_d = cnt_q + 5'd1;
            if (last) begin
                quo_d = {qw_q[WIDTH-2:0], ge};
                rem_d = ge ? trial[WIDTH-1:0] : pr_sh[WIDTH-1:0];
                dbz_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            pr_q  <= '0;
            qw_q  <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            pr_q  <= pr_d;
            qw_q  <= qw_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16.sv
// tb_seq_divider_16: directed corner cases plus randomized operands checked against
// plain integer division, with backpressure, mid-operation reset and handoff counting.
module tb_seq_divider_16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic in_ready, out_valid, div_by_zero;
    logic [15:0] quotient, remainder;
    int n_cmp = 0;
    int n_err = 0;
    int n_hand = 0;

    seq_divider_16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && out_valid && out_ready) n_hand++;

    function automatic logic [15:0] exp_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [15:0] exp_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int exp_lat(input logic [15:0] b);
        return (b == 0) ? 1 : 17;
    endfunction

    function automatic logic [15:0] pick();
        int s = $urandom_range(0, 7);
        return s == 0 ? 16'h0000 : s == 1 ? 16'hFFFF : s == 2 ? 16'h0001 : 16'($urandom);
    endfunction

    // lat counts edges from the accept edge (inclusive) until out_valid is seen
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input bit garbage, output int lat);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (garbage) begin
                in_valid = 1'($urandom);
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_pre_clk got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0000 0000 0", in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_clocked got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0000 0000 0", in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        drive(16'd100, 16'd7, 1'b0, lat);
        n_cmp++;
        if (lat !== 17) begin n_err++; $display("FAIL basic_latency got %0d want 17", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result got q=%0d r=%0d z=%b want q=14 r=2 z=0", quotient, remainder, div_by_zero);
        end
        handoff();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_handoff got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_corners();
        logic [15:0] ta [6] = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd5, 16'd0, 16'hFFFF};
        logic [15:0] tb [6] = '{16'd1, 16'hFFFF, 16'd10, 16'd0, 16'd0, 16'd0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], 1'b0, lat);
            n_cmp++;
            if (lat !== exp_lat(tb[i]) || quotient !== exp_q(ta[i], tb[i]) || remainder !== exp_r(ta[i], tb[i]) || div_by_zero !== (tb[i] == 0)) begin
                n_err++;
                $display("FAIL corner_%0d %0d/%0d got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b", i, ta[i], tb[i], lat, quotient, remainder, div_by_zero, exp_lat(tb[i]), exp_q(ta[i], tb[i]), exp_r(ta[i], tb[i]), tb[i] == 0);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        drive(16'd1000, 16'd33, 1'b1, lat);
        n_cmp++;
        if (lat !== 17 || quotient !== 16'd30 || remainder !== 16'd10) begin
            n_err++;
            $display("FAIL bp_result got lat=%0d q=%0d r=%0d want lat=17 q=30 r=10", lat, quotient, remainder);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd30, 16'd10, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b q=%0d r=%0d z=%b want 1 0 30 10 0", i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        in_valid = 1'b0;
        handoff();
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, 16'd30, 16'd10}) begin
            n_err++;
            $display("FAIL bp_handoff got rdy=%b vld=%b q=%0d r=%0d want 1 0 30 10", in_ready, out_valid, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 16'd123;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0000 0000 0", in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(16'd40000, 16'd123, 1'b0, lat);
        n_cmp++;
        if (lat !== 17 || quotient !== 16'd325 || remainder !== 16'd25 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rerun got lat=%0d q=%0d r=%0d z=%b want lat=17 q=325 r=25 z=0", lat, quotient, remainder, div_by_zero);
        end
        handoff();
    endtask

    task automatic test_random();
        int lat;
        int h0 = n_hand;
        int n = 2000;
        logic [15:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = pick();
            b = pick();
            drive(a, b, 1'b1, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_cmp++;
            if (!out_valid || lat !== exp_lat(b) || quotient !== exp_q(a, b) || remainder !== exp_r(a, b) || div_by_zero !== (b == 0)) begin
                n_err++;
                $display("FAIL rand_%0d %0d/%0d got vld=%b lat=%0d q=%0d r=%0d z=%b want vld=1 lat=%0d q=%0d r=%0d z=%b", i, a, b, out_valid, lat, quotient, remainder, div_by_zero, exp_lat(b), exp_q(a, b), exp_r(a, b), b == 0);
            end
            handoff();
        end
        n_cmp++;
        if (n_hand - h0 !== n) begin
            n_err++;
            $display("FAIL rand_handoffs got %0d want %0d", n_hand - h0, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
